// File: rtl/scalar_postproc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : scalar_postproc_pipe
// Description : Three-stage valid/ready post-processing pipeline for
//               accumulator rows. Per lane it performs:
//               stage 1: saturating bias add
//               stage 2: signed scale multiply
//               stage 3: rounding arithmetic right shift, int8 clamp,
//                        and optional ReLU.
//               Optional feature macro: SCALAR_RELU_EN adds the relu_i port
//               and forces negative clamped results to zero when it is high.
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_postproc_pipe #(
    parameter int LANES       = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int SCALE_WIDTH = 16,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                acc_valid_i,
    output logic                                acc_ready_o,
    input  logic [LANES-1:0][ACC_WIDTH-1:0]     acc_data_i,
    input  logic [LANES-1:0][ACC_WIDTH-1:0]     bias_i,
    input  logic [LANES-1:0][ACC_WIDTH-1:0]     scale_i,
    input  logic [4:0]                          shift_i,
    input  logic                                clear_sat_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [LANES-1:0][OUT_WIDTH-1:0]     out_data_o,
    output logic                                busy_o,
    output logic                                sat_o
`ifdef SCALAR_RELU_EN
    ,
    input  logic                                relu_i
`endif
);

    localparam int c_PROD_W = ACC_WIDTH + SCALE_WIDTH;
    localparam int c_RND_W  = c_PROD_W + 1;

    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    localparam logic signed [c_RND_W-1:0] c_OUT_MAX = c_RND_W'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [c_RND_W-1:0] c_OUT_MIN = c_RND_W'(-(2**(OUT_WIDTH-1)));

    // Stage registers
    logic                               r_v1;
    logic                               r_v2;
    logic                               r_v3;
    logic [LANES-1:0][ACC_WIDTH-1:0]    r_s1;
    logic [LANES-1:0][c_PROD_W-1:0]     r_p;
    logic [LANES-1:0][OUT_WIDTH-1:0]    r_out;
    logic                               r_sat;

    // Per-lane combinational results
    logic [LANES-1:0][ACC_WIDTH-1:0]    w_s1;
    logic [LANES-1:0]                   w_s1_ovf;
    logic [LANES-1:0][c_PROD_W-1:0]     w_prod;
    logic [LANES-1:0][OUT_WIDTH-1:0]    w_out;
    logic [LANES-1:0]                   w_s3_sat;
    logic [LANES-1:0]                   w_unused_scale_hi;

    // Handshake: each stage moves when empty or when its successor moves,
    // so a full pipeline still streams one row per cycle.
    logic w_adv1;
    logic w_adv2;
    logic w_adv3;
    logic w_sat_evt;

    // Rounding increment 2^(shift-1), zero when no shift is requested
    logic signed [c_RND_W-1:0] w_round;

    assign w_adv3 = ~r_v3 | out_ready_i;
    assign w_adv2 = ~r_v2 | w_adv3;
    assign w_adv1 = ~r_v1 | w_adv2;

    assign acc_ready_o = w_adv1;
    assign out_valid_o = r_v3;
    assign out_data_o  = r_out;
    assign busy_o      = r_v1 | r_v2 | r_v3;
    assign sat_o       = r_sat;

    assign w_round = (shift_i == 5'd0) ? '0 : (c_RND_W'(1) << (shift_i - 5'd1));

    // A saturation counts only for a row actually moving into the stage that
    // produced it; stalled rows would otherwise re-report every cycle.
    assign w_sat_evt = (acc_valid_i & w_adv1 & (|w_s1_ovf))
                     | (r_v2 & w_adv3 & (|w_s3_sat));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic        [ACC_WIDTH:0]     w_sum;
        logic signed [c_RND_W-1:0]     w_p_ext;
        logic signed [c_RND_W-1:0]     w_rsum;
        logic signed [c_RND_W-1:0]     w_r;
        logic                          w_hi;
        logic                          w_lo;
        logic        [OUT_WIDTH-1:0]   w_clamp;

        // Bias add at one extra bit; disagreement of the top two bits means overflow
        assign w_sum       = {acc_data_i[l][ACC_WIDTH-1], acc_data_i[l]}
                           + {bias_i[l][ACC_WIDTH-1], bias_i[l]};
        assign w_s1_ovf[l] = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
        assign w_s1[l]     = w_s1_ovf[l] ? (w_sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX)
                                         : w_sum[ACC_WIDTH-1:0];

        // Both operands sign-extended to product width; low bits of the
        // product are then the exact signed result
        assign w_prod[l] = {{SCALE_WIDTH{r_s1[l][ACC_WIDTH-1]}}, r_s1[l]}
                         * {{ACC_WIDTH{scale_i[l][SCALE_WIDTH-1]}}, scale_i[l][SCALE_WIDTH-1:0]};

        assign w_unused_scale_hi[l] = ^scale_i[l][ACC_WIDTH-1:SCALE_WIDTH];

        // One guard bit so the rounding add cannot wrap
        assign w_p_ext = {r_p[l][c_PROD_W-1], r_p[l]};
        assign w_rsum  = w_p_ext + w_round;
        assign w_r     = (shift_i == 5'd0) ? w_p_ext : (w_rsum >>> shift_i);

        assign w_hi    = (w_r > c_OUT_MAX);
        assign w_lo    = (w_r < c_OUT_MIN);
        assign w_clamp = w_hi ? c_OUT_MAX[OUT_WIDTH-1:0]
                       : (w_lo ? c_OUT_MIN[OUT_WIDTH-1:0] : w_r[OUT_WIDTH-1:0]);
        assign w_s3_sat[l] = w_hi | w_lo;

`ifdef SCALAR_RELU_EN
        assign w_out[l] = (relu_i && w_clamp[OUT_WIDTH-1]) ? '0 : w_clamp;
`else
        assign w_out[l] = w_clamp;
`endif
    end

    // Pipeline stage registers and sticky saturation flag; set beats clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_s1  <= '0;
            r_p   <= '0;
            r_out <= '0;
            r_sat <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= acc_valid_i;
                if (acc_valid_i) begin
                    r_s1 <= w_s1;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_p <= w_prod;
                end
            end
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_out <= w_out;
                end
            end
            if (w_sat_evt) begin
                r_sat <= 1'b1;
            end else if (clear_sat_i) begin
                r_sat <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scalar_postproc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_postproc_pipe
// Description : Self-checking bench for scalar_postproc_pipe. Directed
//               scenarios plus randomized valid/ready traffic compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_postproc_pipe;

    localparam int L = 8;
    typedef logic [L-1:0][31:0] row_t;
    typedef logic [L-1:0][7:0]  orow_t;

    logic        clk_i       = 1'b0;
    logic        reset_i     = 1'b1;
    logic        acc_valid_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic        clear_sat_i = 1'b0;
    row_t        acc_data_i  = '0;
    row_t        bias_i      = '0;
    row_t        scale_i     = '0;
    logic [4:0]  shift_i     = '0;
    logic        acc_ready_o;
    logic        out_valid_o;
    logic        busy_o;
    logic        sat_o;
    orow_t       out_data_o;
`ifdef SCALAR_RELU_EN
    logic        relu_i      = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    orow_t exp_q[$];

    scalar_postproc_pipe dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .acc_valid_i (acc_valid_i),
        .acc_ready_o (acc_ready_o),
        .acc_data_i  (acc_data_i),
        .bias_i      (bias_i),
        .scale_i     (scale_i),
        .shift_i     (shift_i),
        .clear_sat_i (clear_sat_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .sat_o       (sat_o)
`ifdef SCALAR_RELU_EN
        ,
        .relu_i      (relu_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #900000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit relu_now();
`ifdef SCALAR_RELU_EN
        return relu_i;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain 64-bit arithmetic straight from the lane rules
    function automatic logic [7:0] lane_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] sc, input int sh,
                                              input bit relu, output bit sat);
        longint s;
        longint p;
        longint r;
        longint amax;
        longint amin;
        logic [15:0] sc16;
        sat  = 1'b0;
        amax = 64'sd2147483647;
        amin = -amax - 1;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > amax) begin s = amax; sat = 1'b1; end
        else if (s < amin) begin s = amin; sat = 1'b1; end
        sc16 = sc[15:0];
        p = s * longint'($signed(sc16));
        if (sh == 0) r = p;
        else         r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 127)       begin r = 127;  sat = 1'b1; end
        else if (r < -128) begin r = -128; sat = 1'b1; end
        if (relu && r < 0) r = 0;
        return r[7:0];
    endfunction

    function automatic orow_t row_model(input row_t a, output bit sat);
        orow_t o;
        bit    s;
        sat = 1'b0;
        for (int l = 0; l < L; l++) begin
            o[l] = lane_model(a[l], bias_i[l], scale_i[l], int'(shift_i), relu_now(), s);
            sat  = sat | s;
        end
        return o;
    endfunction

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 4000)) - 32'd2000;
    endfunction

    function automatic row_t splat(input logic [31:0] v);
        row_t r;
        for (int l = 0; l < L; l++) r[l] = v;
        return r;
    endfunction

    function automatic orow_t splat8(input logic [7:0] v);
        orow_t r;
        for (int l = 0; l < L; l++) r[l] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid_o && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (sat_o !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat_o); end
        total++; if (out_data_o !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data_o); end
        reset_i = 1'b0;
        tick();
        total++; if (acc_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", acc_ready_o); end
    endtask

    task automatic test_basic();
        int n;
        orow_t e;
        out_ready_i = 1'b1;
        bias_i  = splat(32'd28);
        scale_i = splat(32'd3);
        shift_i = 5'd2;
        acc_data_i  = splat(32'd100);
        acc_valid_i = 1'b1;
        #1;
        total++; if (acc_ready_o !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", acc_ready_o); end
        tick();
        acc_valid_i = 1'b0;
        wait_valid(n);
        // cycles counted from the accept cycle itself
        total++; if (n + 1 !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", n + 1); end
        e = splat8(8'd96);
        total++; if (out_data_o !== e) begin bad++; $display("FAIL basic_data got=%h exp=%h", out_data_o, e); end
        total++; if (sat_o !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b exp=0", sat_o); end
        tick();
        total++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b%b exp=00", out_valid_o, busy_o); end
    endtask

    task automatic test_neg_clamp();
        int n;
        orow_t e;
`ifdef SCALAR_RELU_EN
        relu_i = 1'b1;
        e = splat8(8'h00);
`else
        e = splat8(8'h80);
`endif
        bias_i  = splat(32'd0);
        scale_i = splat(32'd1);
        shift_i = 5'd0;
        acc_data_i  = splat(-32'sd1000);
        acc_valid_i = 1'b1;
        tick();
        acc_valid_i = 1'b0;
        wait_valid(n);
        total++; if (out_data_o !== e) begin bad++; $display("FAIL neg_clamp_data got=%h exp=%h", out_data_o, e); end
        total++; if (sat_o !== 1'b1) begin bad++; $display("FAIL neg_clamp_sat got=%b exp=1", sat_o); end
        tick();
        total++; if (sat_o !== 1'b1) begin bad++; $display("FAIL neg_clamp_sticky got=%b exp=1", sat_o); end
        clear_sat_i = 1'b1;
        tick();
        clear_sat_i = 1'b0;
        total++; if (sat_o !== 1'b0) begin bad++; $display("FAIL neg_clamp_clear got=%b exp=0", sat_o); end
`ifdef SCALAR_RELU_EN
        relu_i = 1'b0;
`endif
    endtask

    task automatic test_bias_sat();
        int n;
        orow_t e;
        bias_i  = splat(32'd1);
        scale_i = splat(32'd1);
        acc_data_i = splat(32'h7FFF_FFFF);
        // shift 24 overflows the int8 range; shift 31 exposes the stage-1 value
        for (int k = 0; k < 2; k++) begin
            shift_i = (k == 0) ? 5'd24 : 5'd31;
            e = (k == 0) ? splat8(8'd127) : splat8(8'd1);
            acc_valid_i = 1'b1;
            tick();
            acc_valid_i = 1'b0;
            total++; if (sat_o !== 1'b1) begin bad++; $display("FAIL bias_sat_flag%0d got=%b exp=1", k, sat_o); end
            wait_valid(n);
            total++; if (out_data_o !== e) begin bad++; $display("FAIL bias_sat_data%0d got=%h exp=%h", k, out_data_o, e); end
            tick();
            clear_sat_i = 1'b1;
            tick();
            clear_sat_i = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int idx = 1;
        int acc_cnt = 0;
        int got = 0;
        int cyc = 0;
        bit s;
        orow_t e;
        row_t r;
        bias_i  = splat(32'd0);
        scale_i = splat(32'd1);
        shift_i = 5'd0;
        out_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int l = 0; l < L; l++) r[l] = 32'(idx + 16 * l);
            acc_data_i  = r;
            acc_valid_i = 1'b1;
            #1;
            if (acc_ready_o) begin
                exp_q.push_back(row_model(r, s));
                idx++;
                acc_cnt++;
            end
            tick();
        end
        total++; if (acc_cnt !== 3) begin bad++; $display("FAIL bp_accepted got=%0d exp=3", acc_cnt); end
        for (int l = 0; l < L; l++) r[l] = 32'(idx + 16 * l);
        acc_data_i = r;
        #1;
        total++; if (acc_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", acc_ready_o); end
        out_ready_i = 1'b1;
        #1;
        total++; if (acc_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_drain got=%b exp=1", acc_ready_o); end
        while (got < 4 && cyc < 20) begin
            acc_valid_i = (idx <= 4);
            for (int l = 0; l < L; l++) r[l] = 32'(idx + 16 * l);
            acc_data_i = r;
            #1;
            if (out_valid_o && out_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra_row got=%h exp=none", out_data_o); end
                else begin
                    e = exp_q.pop_front();
                    if (out_data_o !== e || out_data_o[0] !== 8'(got + 1)) begin
                        bad++; $display("FAIL bp_order got=%h exp=%h", out_data_o, e);
                    end
                end
                got++;
            end
            if (acc_valid_i && acc_ready_o) begin
                exp_q.push_back(row_model(r, s));
                idx++;
            end
            tick();
            cyc++;
        end
        acc_valid_i = 1'b0;
        total++; if (got !== 4) begin bad++; $display("FAIL bp_drain_count got=%0d exp=4", got); end
    endtask

    task automatic test_random();
        bit s;
        orow_t e;
        row_t cur;
        for (int b = 0; b < 20; b++) begin
            int sent = 0;
            int got = 0;
            int cyc = 0;
            bit pend = 1'b0;
            for (int l = 0; l < L; l++) begin
                bias_i[l]  = rnd_val();
                scale_i[l] = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 128)) - 32'd64);
            end
            shift_i = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(13, 31)) : 5'($urandom_range(0, 12));
`ifdef SCALAR_RELU_EN
            relu_i = 1'($urandom_range(0, 1));
`endif
            while (got < 50 && cyc < 3000) begin
                if (!pend && sent < 50 && $urandom_range(0, 1) == 1) begin
                    for (int l = 0; l < L; l++) cur[l] = rnd_val();
                    pend = 1'b1;
                end
                acc_valid_i = pend;
                acc_data_i  = cur;
                out_ready_i = ($urandom_range(0, 2) != 0);
                #1;
                total++;
                if (busy_o !== (exp_q.size() != 0)) begin
                    bad++; $display("FAIL rnd_busy got=%b exp=%b", busy_o, exp_q.size() != 0);
                end
                if (out_valid_o && out_ready_i) begin
                    total++;
                    if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_extra_row got=%h exp=none", out_data_o); end
                    else begin
                        e = exp_q.pop_front();
                        if (out_data_o !== e) begin bad++; $display("FAIL rnd_data got=%h exp=%h", out_data_o, e); end
                    end
                    got++;
                end
                if (acc_valid_i && acc_ready_o) begin
                    exp_q.push_back(row_model(cur, s));
                    sent++;
                    pend = 1'b0;
                end
                tick();
                cyc++;
            end
            acc_valid_i = 1'b0;
            total++; if (got !== 50) begin bad++; $display("FAIL rnd_batch_count got=%0d exp=50", got); end
        end
`ifdef SCALAR_RELU_EN
        relu_i = 1'b0;
`endif
        clear_sat_i = 1'b1;
        tick();
        clear_sat_i = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        int n;
        orow_t e;
        bit s;
        out_ready_i = 1'b0;
        bias_i  = splat(32'd1);
        scale_i = splat(32'd1);
        shift_i = 5'd31;
        acc_data_i  = splat(32'h7FFF_FFFF);
        acc_valid_i = 1'b1;
        tick();
        tick();
        acc_valid_i = 1'b0;
        total++; if (busy_o !== 1'b1 || sat_o !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b%b exp=11", busy_o, sat_o); end
        #2;
        reset_i = 1'b1;
        #1;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
        total++; if (sat_o !== 1'b0) begin bad++; $display("FAIL midrst_sat got=%b exp=0", sat_o); end
        total++; if (out_data_o !== '0) begin bad++; $display("FAIL midrst_data got=%h exp=0", out_data_o); end
        tick();
        reset_i = 1'b0;
        out_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid_o || busy_o) stale++;
            tick();
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
        bias_i = splat(32'd0);
        shift_i = 5'd0;
        acc_data_i = splat(32'd42);
        e = row_model(acc_data_i, s);
        acc_valid_i = 1'b1;
        tick();
        acc_valid_i = 1'b0;
        wait_valid(n);
        total++; if (out_data_o !== e || n !== 2) begin bad++; $display("FAIL midrst_after got=%h/%0d exp=%h/2", out_data_o, n, e); end
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_basic();
        test_neg_clamp();
        test_bias_sat();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
